// File: rtl/intr_ctrl.sv
// Interrupt controller for the jacaranda-8 core. It latches rising-edge requests,
// picks the lowest-index enabled source and redirects the core, then redirects it back on reti.
module intr_ctrl #(
    parameter int              N_SRC = 4,
    parameter int              PC_W  = 8,
    parameter logic [PC_W-1:0] VEC0  = 8'h10,
    parameter logic [PC_W-1:0] VEC1  = 8'h20,
    parameter logic [PC_W-1:0] VEC2  = 8'h30,
    parameter logic [PC_W-1:0] VEC3  = 8'h40
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq,
    input  logic             ien_we,
    input  logic [N_SRC-1:0] ien_wdata,
    input  logic             insn_boundary,
    input  logic [PC_W-1:0]  next_pc,
    input  logic             reti,
    output logic             intr_en,
    output logic             take,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [1:0]       cause,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] ien
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVICE = 2'd1,
        ST_RETURN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] ien_q, ien_d;
    logic [PC_W-1:0]  epc_q, epc_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;
    logic [1:0]       cause_q, cause_d;
    logic             take_q, take_d;
    logic             intr_en_q, intr_en_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] clr;
    logic [1:0]       winner;

    // Lowest set index wins; scanning downward lets the last hit be the smallest.
    function automatic logic [1:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [PC_W-1:0] vector_of(input logic [1:0] idx);
        logic [PC_W-1:0] v;
        case (idx)
            2'd0:    v = VEC0;
            2'd1:    v = VEC1;
            2'd2:    v = VEC2;
            default: v = VEC3;
        endcase
        return v;
    endfunction

    always_comb begin
        rise       = irq & ~irq_prev_q;
        elig       = pending_q & ien_q;
        winner     = lowest_idx(elig);

        state_d    = state_q;
        clr        = '0;
        epc_d      = epc_q;
        cause_d    = cause_q;
        redirect_d = redirect_q;
        take_d     = 1'b0;
        intr_en_d  = intr_en_q;

        case (state_q)
            ST_IDLE: begin
                intr_en_d = 1'b0;
                if (insn_boundary && (elig != '0)) begin
                    clr[winner] = 1'b1;
                    epc_d       = next_pc;
                    cause_d     = winner;
                    redirect_d  = vector_of(winner);
                    take_d      = 1'b1;
                    intr_en_d   = 1'b1;
                    state_d     = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                // Further pendings just accumulate here: no nesting.
                if (reti) begin
                    redirect_d = epc_q;
                    take_d     = 1'b1;
                    intr_en_d  = 1'b0;
                    state_d    = ST_RETURN;
                end
            end
            ST_RETURN: begin
                // No arbitration here so the core fetches epc before any re-entry.
                intr_en_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                intr_en_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // A rise on the bit being cleared keeps it set.
        pending_d  = (pending_q & ~clr) | rise;
        ien_d      = ien_we ? ien_wdata : ien_q;
        irq_prev_d = irq;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            ien_q      <= '0;
            epc_q      <= '0;
            redirect_q <= '0;
            cause_q    <= '0;
            take_q     <= 1'b0;
            intr_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            ien_q      <= ien_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
            cause_q    <= cause_d;
            take_q     <= take_d;
            intr_en_q  <= intr_en_d;
        end
    end

    assign intr_en     = intr_en_q;
    assign take        = take_q;
    assign redirect_pc = redirect_q;
    assign cause       = cause_q;
    assign pending     = pending_q;
    assign ien         = ien_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus random traffic, all cycles compared
// against a behavioural model of the interrupt rules.
module tb_intr_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] irq;
    logic       ien_we;
    logic [3:0] ien_wdata;
    logic       insn_boundary;
    logic [7:0] next_pc;
    logic       reti;
    logic       intr_en;
    logic       take;
    logic [7:0] redirect_pc;
    logic [1:0] cause;
    logic [3:0] pending;
    logic [3:0] ien;

    int checks   = 0;
    int failures = 0;

    intr_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .irq          (irq),
        .ien_we       (ien_we),
        .ien_wdata    (ien_wdata),
        .insn_boundary(insn_boundary),
        .next_pc      (next_pc),
        .reti         (reti),
        .intr_en      (intr_en),
        .take         (take),
        .redirect_pc  (redirect_pc),
        .cause        (cause),
        .pending      (pending),
        .ien          (ien)
    );

    always #5 clock = ~clock;

    // Behavioural model: mode 0 = normal code, 1 = inside handler, 2 = returning.
    int         m_mode;
    logic [3:0] m_prev, m_pend, m_ien;
    logic [7:0] m_epc, m_red;
    logic [1:0] m_cause;
    logic       m_take, m_inten;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = '0; m_pend = '0; m_ien = '0;
        m_epc = '0; m_red = '0; m_cause = '0; m_take = 0; m_inten = 0;
    endtask

    task automatic model_step();
        logic [3:0] rise, elig, clr;
        int w;
        rise = irq & ~m_prev;
        elig = m_pend & m_ien;
        clr  = '0;
        m_take = 0;
        if (m_mode == 0) begin
            if (insn_boundary && elig != 0) begin
                w = 0;
                while (!elig[w]) w++;
                clr[w]  = 1'b1;
                m_epc   = next_pc;
                m_cause = 2'(w);
                m_red   = 8'(16 * (w + 1));
                m_take  = 1;
                m_inten = 1;
                m_mode  = 1;
            end
        end else if (m_mode == 1) begin
            if (reti) begin
                m_red   = m_epc;
                m_take  = 1;
                m_inten = 0;
                m_mode  = 2;
            end
        end else begin
            m_mode = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        m_prev = irq;
        if (ien_we) m_ien = ien_wdata;
    endtask

    task automatic compare_all();
        check("intr_en", 32'(intr_en), 32'(m_inten));
        check("take", 32'(take), 32'(m_take));
        check("redirect_pc", 32'(redirect_pc), 32'(m_red));
        check("cause", 32'(cause), 32'(m_cause));
        check("pending", 32'(pending), 32'(m_pend));
        check("ien", 32'(ien), 32'(m_ien));
    endtask

    // Inputs change at the negedge; the model steps on the posedge; outputs checked at the next negedge.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle_inputs();
        irq = '0; ien_we = 0; ien_wdata = '0; insn_boundary = 0; next_pc = '0; reti = 0;
    endtask

    task automatic write_ien(input logic [3:0] m);
        ien_we = 1; ien_wdata = m; tick(); ien_we = 0;
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        model_reset();
        #12;
        check("rst_intr_en", 32'(intr_en), 0);
        check("rst_take", 32'(take), 0);
        check("rst_redirect", 32'(redirect_pc), 0);
        check("rst_cause", 32'(cause), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_ien", 32'(ien), 0);
        @(negedge clock);
        reset_n = 1;
        tick();

        // Single source, latency and bank select
        write_ien(4'b0010);
        insn_boundary = 1; next_pc = 8'h57;
        irq = 4'b0010;
        tick();
        check("lat_no_take_n1", 32'(take), 0);
        tick();
        check("lat_take", 32'(take), 1);
        check("lat_vec", 32'(redirect_pc), 32'h20);
        check("lat_cause", 32'(cause), 1);
        check("lat_inten", 32'(intr_en), 1);
        check("lat_pend_clr", 32'(pending[1]), 0);
        irq = '0;
        tick();
        check("service_take_low", 32'(take), 0);
        reti = 1;
        tick();
        check("reti_take", 32'(take), 1);
        check("reti_epc", 32'(redirect_pc), 32'h57);
        check("reti_inten", 32'(intr_en), 0);
        reti = 0;
        tick();
        check("return_done", 32'(take), 0);
        reti = 1;
        tick();
        tick();
        check("reti_idle_take", 32'(take), 0);
        check("reti_idle_inten", 32'(intr_en), 0);
        reti = 0;

        // Simultaneous sources: lowest index first, other serviced after return
        write_ien(4'hF);
        irq = 4'b1001; next_pc = 8'h66;
        tick();
        irq = '0;
        tick();
        check("prio_cause", 32'(cause), 0);
        check("prio_vec", 32'(redirect_pc), 32'h10);
        check("prio_pend3", 32'(pending[3]), 1);
        reti = 1;
        tick();
        check("prio_ret_epc", 32'(redirect_pc), 32'h66);
        reti = 0;
        tick();
        check("prio_idle_gap", 32'(take), 0);
        tick();
        check("prio_reentry_take", 32'(take), 1);
        check("prio_reentry_cause", 32'(cause), 3);
        check("prio_reentry_vec", 32'(redirect_pc), 32'h40);
        reti = 1; tick(); reti = 0; tick();

        // Mask write uses the old mask in its own cycle
        write_ien(4'b0000);
        irq = 4'b0100;
        tick(); tick(); tick();
        check("masked_no_take", 32'(take), 0);
        ien_we = 1; ien_wdata = 4'b0100;
        tick();
        ien_we = 0;
        check("mask_m_no_take", 32'(take), 0);
        tick();
        check("mask_m2_take", 32'(take), 1);
        check("mask_m2_cause", 32'(cause), 2);
        irq = '0;
        reti = 1; tick(); reti = 0; tick();

        // Clear and fresh rise of the same bit in the acceptance cycle
        write_ien(4'b0010);
        insn_boundary = 0;
        irq = 4'b0010; tick();
        irq = 4'b0000; tick();
        irq = 4'b0010; insn_boundary = 1; next_pc = 8'h3c;
        tick();
        check("race_take", 32'(take), 1);
        check("race_pend_kept", 32'(pending[1]), 1);
        irq = '0;
        reti = 1; tick(); reti = 0; tick(); tick();
        check("race_reentry", 32'(take), 1);
        check("race_reentry_cause", 32'(cause), 1);

        // Asynchronous reset mid-handler, irq held through release
        tick();
        irq = 4'b0001;
        #2 reset_n = 0;
        #1;
        check("arst_inten", 32'(intr_en), 0);
        check("arst_take", 32'(take), 0);
        check("arst_pending", 32'(pending), 0);
        check("arst_ien", 32'(ien), 0);
        model_reset();
        @(negedge clock);
        reset_n = 1;
        tick();
        check("arst_held_irq", 32'(pending[0]), 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            irq           = 4'($urandom_range(0, 15));
            ien_we        = ($urandom_range(0, 15) == 0);
            ien_wdata     = 4'($urandom_range(0, 15));
            insn_boundary = ($urandom_range(0, 2) != 0);
            next_pc       = 8'($urandom_range(0, 255));
            reti          = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller for the jacaranda-8 core.
- Collects peripheral interrupt requests, arbitrates them and redirects the core to a handler.
- Drives the `intr_en` bank-select that the register file uses to swap to its shadow bank during handlers.
- Saves the return PC on entry and restores it on `reti`; nesting is not supported.

Parameters:
- N_SRC, 4, number of interrupt sources; fixed at 4, so `cause` is 2 bits.
- PC_W, 8, program-counter width.
- VEC0, 8'h10, handler address for source 0.
- VEC1, 8'h20, handler address for source 1.
- VEC2, 8'h30, handler address for source 2.
- VEC3, 8'h40, handler address for source 3.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- irq  in  N_SRC  peripheral requests, same clock domain; rising-edge sensitive.
- ien_we  in  1  write strobe for the enable mask.
- ien_wdata  in  N_SRC  new enable mask.
- insn_boundary  in  1  core is between instructions; `next_pc` is valid.
- next_pc  in  PC_W  address the core would fetch next.
- reti  in  1  a `reti` instruction is retiring this cycle.
- intr_en  out  1  shadow-bank select to the register file; high while in a handler.
- take  out  1  one-cycle pulse: core must load `redirect_pc` as its PC.
- redirect_pc  out  PC_W  redirect target; valid while `take`=1.
- cause  out  2  index of the source being serviced.
- pending  out  N_SRC  latched pending bits.
- ien  out  N_SRC  current enable mask.

Behaviour:
- Reset (`reset_n`=0, asynchronous):
  - state=IDLE.
  - intr_en=0, take=0, redirect_pc=0, cause=0, pending=0, ien=0, epc=0.
  - irq_prev=0, so an irq held high across reset release sets its pending bit on the first clock.
- Edge detect:
  - `rise[i] = irq[i] & ~irq_prev[i]`.
  - `irq_prev <= irq` every cycle.
- Pending:
  - `pending[i] <= (pending[i] & ~clr[i]) | rise[i]`.
  - If rise and clear hit the same bit in the same cycle, the rise wins (bit stays set).
- Mask:
  - `ien <= ien_wdata` when `ien_we`=1, in any state.
  - Arbitration in a cycle with `ien_we`=1 uses the old mask.
- Eligible: `elig = pending & ien`. Priority: lowest index wins.
- States:
  - IDLE:
    - intr_en=0.
    - If `insn_boundary` and `elig`≠0: epc<=next_pc; cause<=winner index; clr[winner]=1; redirect_pc<=VEC[winner]; take<=1; intr_en<=1; go to SERVICE.
    - Otherwise stay. A `reti` in IDLE is ignored.
  - SERVICE:
    - intr_en=1. take is high only in the first SERVICE cycle (registered pulse).
    - New pendings accumulate but are not taken (no nesting).
    - On `reti`: redirect_pc<=epc; take<=1; intr_en<=0; go to RETURN.
  - RETURN:
    - Lasts exactly one cycle; take=1 this cycle; intr_en=0.
    - Arbitration is suppressed, so the core fetches from epc before any re-entry.
    - Unconditionally goes to IDLE.
- Latency:
  - From the first irq rising edge to `take`: pending sets at edge N, eligibility is evaluated in cycle N+1, `take` is high in cycle N+2, provided `insn_boundary`=1 in cycle N+1 and the source is enabled.
  - From `reti` to `take`: 1 cycle.
- Bank timing:
  - intr_en is registered, so the register-file write of the instruction at the accepting boundary lands in the normal bank.
  - The first handler instruction writes the shadow bank.
  - The `reti` cycle itself still sees intr_en=1.
- Outputs are registered. redirect_pc holds its last value when take=0.
- An asynchronous reset mid-handler returns the block to IDLE with intr_en=0 immediately, without waiting for a clock.

Test Plan:
- ien=4'b0010, irq[1] rises at edge N, insn_boundary=1, next_pc=8'h57 -> take=1 in cycle N+2, redirect_pc=8'h20, cause=1, intr_en=1 from the same cycle, pending[1]=0.
- Same cycle both: irq[3] and irq[0] rise, ien=4'hF -> cause=0, redirect=8'h10; pending[3] stays 1; after reti, one RETURN cycle, then re-entry with cause=3, redirect=8'h40.
- In SERVICE, reti with saved epc=8'h57 -> take=1, redirect_pc=8'h57 next cycle, intr_en=0; reti asserted in IDLE -> no take, state unchanged.
- irq[2] pending with ien=0 -> no take; write ien_wdata=4'b0100 in cycle M with insn_boundary=1 -> no take from cycle M's evaluation, take in cycle M+2.
- Pending clear and new irq[1] rise in the acceptance cycle -> pending[1]=1 afterwards; serviced after the first reti.
- Pull reset_n low mid-SERVICE -> intr_en, take, pending, ien all 0 asynchronously; irq held high through release -> pending bit set on the first clock.
